// File: rtl/uart_rx_digits_if.sv
// uart_rx_digits_if: signal bundle between the UART digit receiver and its
// environment.
//
// Signals
//   Rxd          serial line into the receiver, idles high
//   LED0..LED3   BCD digits of the last complete group (LED0 first received)
//   byte_out     last correctly framed byte
//   byte_valid   one-cycle pulse, byte_out updated
//   frame_valid  one-cycle pulse, LED0..LED3 updated
//   err_framing  one-cycle pulse, bad stop bit (or bad parity when enabled)
//   err_char     one-cycle pulse, received byte is not a digit, CR or LF
//
// Modports
//   master  the receiver: drives everything except Rxd
//   slave   the line driver / display side
interface uart_rx_digits_if;
    logic       Rxd;
    logic [3:0] LED0;
    logic [3:0] LED1;
    logic [3:0] LED2;
    logic [3:0] LED3;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       frame_valid;
    logic       err_framing;
    logic       err_char;

    modport master (
        input  Rxd,
        output LED0, LED1, LED2, LED3,
        output byte_out, byte_valid, frame_valid, err_framing, err_char
    );

    modport slave (
        output Rxd,
        input  LED0, LED1, LED2, LED3,
        input  byte_out, byte_valid, frame_valid, err_framing, err_char
    );
endinterface

// File: rtl/uart_rx_digits.sv
// uart_rx_digits: UART receive stage in front of the seven-segment display.
// Deserialises 8N1 frames from Rxd, converts ASCII '0'-'9' to BCD and loads
// four digits at a time into LED0..LED3. CR/LF restart the digit group;
// other characters raise err_char; a low stop bit raises err_framing.
//
// Ports
//   clk   system clock, all logic on the rising edge
//   rst   synchronous active-low reset
//   bus   uart_rx_digits_if.master
//           in : Rxd
//           out: LED0..LED3, byte_out, byte_valid, frame_valid,
//                err_framing, err_char
//
// Build option
//   RX_PARITY_EN  undefined: plain 8N1.
//                 defined  : an even-parity bit follows the data (11-bit
//                 frame); a parity mismatch with a good stop bit drops the
//                 byte and pulses err_framing.
//
// State  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle, waiting for a falling edge on the synchronised line
// START  | start bit seen, confirm it is still low at mid-bit
// DATA   | sampling 8 data bits, LSB first, one every OVERSAMPLE ticks
// PARITY | sampling the parity bit (RX_PARITY_EN builds only)
// STOP   | sampling the stop bit; good -> byte_valid, bad -> err_framing
// BREAK  | line stuck low after a framing error, wait for it to go high
module uart_rx_digits #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int OVERSAMPLE = 16,
    parameter int DIV        = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
    input  logic             clk,
    input  logic             rst,
    uart_rx_digits_if.master bus
);

    localparam int TCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SCW = $clog2(OVERSAMPLE);
    localparam logic [TCW-1:0] TICK_LAST = TCW'(DIV - 1);
    localparam logic [SCW-1:0] SAMP_MID  = SCW'(OVERSAMPLE / 2 - 1);
    localparam logic [SCW-1:0] SAMP_LAST = SCW'(OVERSAMPLE - 1);

`ifdef RX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif
    // The line must be seen high for a whole frame time before the first
    // start edge is accepted after reset. A reset that lands mid-frame can
    // otherwise mistake a later 0 data bit for a start bit.
    localparam int IDLE_TICKS = OVERSAMPLE * FRAME_BITS;
    localparam int ICW        = $clog2(IDLE_TICKS + 1);
    localparam logic [ICW-1:0] IDLE_DONE = ICW'(IDLE_TICKS);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef RX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4,
        S_BREAK  = 3'd5
    } state_t;

    // line synchroniser and edge detect
    logic           sync1_q;
    logic           rxs_q;
    logic           rxs_prev_q;

    // receive path
    state_t         state_q,      state_d;
    logic [TCW-1:0] tick_cnt_q,   tick_cnt_d;
    logic [SCW-1:0] samp_q,       samp_d;
    logic [2:0]     bit_cnt_q,    bit_cnt_d;
    logic [7:0]     shift_q,      shift_d;
    logic           armed_q,      armed_d;
    logic [ICW-1:0] idle_cnt_q,   idle_cnt_d;
    logic [7:0]     byte_out_q,   byte_out_d;
    logic           byte_valid_q, byte_valid_d;
    logic           err_frm_q,    err_frm_d;
`ifdef RX_PARITY_EN
    logic           par_err_q,    par_err_d;
`endif

    // digit assembly
    logic [1:0]       pos_q,      pos_d;
    logic [2:0][3:0]  shadow_q,   shadow_d;
    logic [3:0][3:0]  led_q,      led_d;
    logic             frame_valid_q, frame_valid_d;
    logic             err_char_q,    err_char_d;

    logic tick;
    logic samp_mid;
    logic samp_last;
    logic start_edge;
    logic is_digit;
    logic is_eol;

    // ------------------------------------------------------------------
    // Synchroniser. Reset to 1 so that reset itself never looks like an
    // edge; a line already low is caught by the arming logic instead.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q    <= 1'b1;
            rxs_q      <= 1'b1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync1_q    <= bus.Rxd;
            rxs_q      <= sync1_q;
            rxs_prev_q <= rxs_q;
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            tick_cnt_q    <= '0;
            samp_q        <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            armed_q       <= 1'b0;
            idle_cnt_q    <= '0;
            byte_out_q    <= '0;
            byte_valid_q  <= 1'b0;
            err_frm_q     <= 1'b0;
`ifdef RX_PARITY_EN
            par_err_q     <= 1'b0;
`endif
            pos_q         <= '0;
            shadow_q      <= '0;
            led_q         <= '0;
            frame_valid_q <= 1'b0;
            err_char_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            samp_q        <= samp_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            armed_q       <= armed_d;
            idle_cnt_q    <= idle_cnt_d;
            byte_out_q    <= byte_out_d;
            byte_valid_q  <= byte_valid_d;
            err_frm_q     <= err_frm_d;
`ifdef RX_PARITY_EN
            par_err_q     <= par_err_d;
`endif
            pos_q         <= pos_d;
            shadow_q      <= shadow_d;
            led_q         <= led_d;
            frame_valid_q <= frame_valid_d;
            err_char_q    <= err_char_d;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM, tick generator and arming
    // ------------------------------------------------------------------
    always_comb begin
        tick       = (tick_cnt_q == TICK_LAST);
        samp_mid   = tick && (samp_q == SAMP_MID);
        samp_last  = tick && (samp_q == SAMP_LAST);
        start_edge = armed_q && rxs_prev_q && !rxs_q;

        state_d      = state_q;
        tick_cnt_d   = tick ? '0 : tick_cnt_q + 1'b1;
        samp_d       = tick ? samp_q + 1'b1 : samp_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        armed_d      = armed_q;
        idle_cnt_d   = idle_cnt_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = 1'b0;
        err_frm_d    = 1'b0;
`ifdef RX_PARITY_EN
        par_err_d    = par_err_q;
`endif

        if (!armed_q) begin
            if (!rxs_q) begin
                idle_cnt_d = '0;
            end else if (idle_cnt_q == IDLE_DONE) begin
                armed_d = 1'b1;
            end else if (tick) begin
                idle_cnt_d = idle_cnt_q + 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    state_d    = S_START;
                    tick_cnt_d = '0;
                    samp_d     = '0;
                end
            end

            S_START: begin
                if (samp_mid) begin
                    samp_d    = '0;
                    bit_cnt_d = '0;
                    state_d   = rxs_q ? S_IDLE : S_DATA;
                end
            end

            S_DATA: begin
                if (samp_last) begin
                    samp_d    = '0;
                    shift_d   = {rxs_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end

`ifdef RX_PARITY_EN
            S_PARITY: begin
                if (samp_last) begin
                    samp_d    = '0;
                    // even parity: XOR of data and parity bit must be 0
                    par_err_d = ^{shift_q, rxs_q};
                    state_d   = S_STOP;
                end
            end
`endif

            S_STOP: begin
                if (samp_last) begin
                    samp_d = '0;
                    if (rxs_q) begin
                        state_d = S_IDLE;
`ifdef RX_PARITY_EN
                        if (par_err_q) begin
                            err_frm_d = 1'b1;
                        end else begin
                            byte_out_d   = shift_q;
                            byte_valid_d = 1'b1;
                        end
`else
                        byte_out_d   = shift_q;
                        byte_valid_d = 1'b1;
`endif
                    end else begin
                        err_frm_d = 1'b1;
                        state_d   = S_BREAK;
                    end
                end
            end

            S_BREAK: begin
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Digit decode, one cycle after byte_valid
    // ------------------------------------------------------------------
    always_comb begin
        is_digit = (byte_out_q[7:4] == 4'h3) && (byte_out_q[3:0] <= 4'd9);
        is_eol   = (byte_out_q == 8'h0D) || (byte_out_q == 8'h0A);

        pos_d         = pos_q;
        shadow_d      = shadow_q;
        led_d         = led_q;
        frame_valid_d = 1'b0;
        err_char_d    = 1'b0;

        if (byte_valid_q) begin
            if (is_digit) begin
                if (pos_q == 2'd3) begin
                    // fourth digit goes straight to LED3; the whole group
                    // is published together
                    led_d         = {byte_out_q[3:0], shadow_q[2], shadow_q[1], shadow_q[0]};
                    frame_valid_d = 1'b1;
                    pos_d         = 2'd0;
                end else begin
                    shadow_d[pos_q] = byte_out_q[3:0];
                    pos_d           = pos_q + 1'b1;
                end
            end else if (is_eol) begin
                pos_d = 2'd0;
            end else begin
                err_char_d = 1'b1;
            end
        end
    end

    assign bus.LED0        = led_q[0];
    assign bus.LED1        = led_q[1];
    assign bus.LED2        = led_q[2];
    assign bus.LED3        = led_q[3];
    assign bus.byte_out    = byte_out_q;
    assign bus.byte_valid  = byte_valid_q;
    assign bus.frame_valid = frame_valid_q;
    assign bus.err_framing = err_frm_q;
    assign bus.err_char    = err_char_q;

endmodule

// File: doc/uart_rx_digits.md
Name: uart_rx_digits

Overview:
- Serial receive stage that sits upstream of the seven-segment display path.
- Deserialises 8N1 UART frames arriving from the laptop on Rxd and converts ASCII '0'–'9' to BCD.
- Collects four digits and loads them as a group into the LED0..LED3 digit registers, which drive the display and the transmit-back path.
- Also reports framing errors and non-digit characters.

Parameters:
- CLK_FREQ, 100000000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- OVERSAMPLE, 16, samples per bit. Must be even and at least 8.
- DIV, CLK_FREQ/(BAUD*OVERSAMPLE) (integer, truncated; 651 at defaults), clock cycles per sample tick.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset. 0 resets the block on the next clk edge.
- Rxd  in  1  asynchronous serial line; idles high.
- LED0  out  4  BCD digit 0 (first received).
- LED1  out  4  BCD digit 1.
- LED2  out  4  BCD digit 2.
- LED3  out  4  BCD digit 3 (last received).
- byte_out  out  8  last correctly framed byte.
- byte_valid  out  1  one-cycle pulse; byte_out was updated.
- frame_valid  out  1  one-cycle pulse; LED0..LED3 were updated.
- err_framing  out  1  one-cycle pulse; stop bit sampled low.
- err_char  out  1  one-cycle pulse; received byte is not a digit, CR or LF.

Behaviour:
- Reset values (rst=0 at a clk edge):
  - LED0..LED3=0, byte_out=0, all pulse outputs 0.
  - Digit position=0, shadow digits=0, state IDLE, synchroniser flops=1, tick counter=0.
- Rxd passes through a 2-flop synchroniser, giving rxs. All sampling uses rxs.
- Tick generator:
  - Counter runs 0..DIV-1 and emits a 1-cycle tick at DIV-1, then wraps.
  - It restarts from 0 when leaving IDLE, so sampling is phase-aligned to the start edge.
- Start detection in IDLE: start is rxs=0 with the previous rxs=1, i.e. a falling edge. A line held low out of reset is ignored until it returns high.
- States and transitions:
  - IDLE -> START on a falling edge; sample-tick count cleared.
  - START: at tick OVERSAMPLE/2 (mid-bit) sample rxs.
    - 1 -> IDLE (glitch, nothing reported).
    - 0 -> DATA, tick count cleared.
  - DATA: every OVERSAMPLE ticks sample one bit, LSB first, into the shift register. After the 8th bit -> STOP (-> PARITY when RX_PARITY_EN is defined).
  - STOP: after OVERSAMPLE ticks sample rxs.
    - 1 -> byte_out<=shift register and byte_valid=1 for one cycle, then IDLE.
    - 0 -> err_framing=1 for one cycle, byte discarded -> BREAK.
  - BREAK: wait for rxs=1, then IDLE. A line stuck low produces no repeated errors.
- Decode happens in the cycle after byte_valid:
  - 0x30–0x39: shadow[pos]<=byte-0x30, pos<=pos+1.
    - When pos==3, LED0..LED2<=shadow[0..2] and LED3<=the new digit, all in that cycle. frame_valid=1 for that cycle, and pos wraps to 0.
  - 0x0D or 0x0A: pos<=0, partial digits discarded, LEDs unchanged, no pulse.
  - Any other byte: err_char=1 for one cycle; pos and the shadow digits are unchanged.
- Latency: stop-bit sample tick -> byte_valid is 1 clk; byte_valid -> frame_valid/LED update/err_char is 1 clk.
- LED outputs change only on frame_valid, so the display never shows a partial group.
- Back-to-back frames, where a start edge arrives immediately after a stop bit is sampled high, must be received with no loss. Decode completes well before the next start bit.
- Reset mid-frame: the frame is aborted, pos=0, shadow cleared, no pulse generated. The remainder of that frame is ignored until the line idles high and a new falling edge occurs.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - A PARITY state sits between DATA and STOP and samples a 9th bit.
  - Even parity over data+parity is required.
  - On mismatch, after a valid stop bit: no byte_valid, err_framing pulses (shared flag), and the byte is discarded.
  - Frame length is 11 bits.
- Not defined: plain 8N1, no PARITY state, no parity logic synthesised.

Test Plan:
- Defaults (bit period 10416 clks): send '1','2','3','4' as 8N1 -> four byte_valid pulses with byte_out 0x31..0x34. One frame_valid pulse 1 clk after the 4th byte_valid; LED0..3=1,2,3,4.
- Send '5','6', CR, then '7','8','9','0' -> no frame_valid after CR; after '0', LED0..3=7,8,9,0.
- Send 'A' (0x41) between '1' and '2', then send '3','4' -> err_char pulse once; LED0..3=1,2,3,4 after '4'.
- Frame with stop bit forced 0 -> err_framing pulse, no byte_valid. Hold Rxd low 50000 clks -> no further pulses. Release high, send '9' -> byte_valid with 0x39.
- Rxd low pulse of 3000 clks (shorter than half a bit) -> no byte_valid and no errors. Assert rst=0 for 1 clk midway through a '7' frame -> all outputs return to reset values, and no byte is reported for that frame.
- With RX_PARITY_EN: '3' with correct even parity -> byte_valid 0x33; same byte with inverted parity -> err_framing only.
